// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   ADDRESS_WIDTH / DATA_WIDTH : default PC and instruction widths
//   RESET_PC                   : default first fetch address after reset
//   fetch_entry_t              : one fetched instruction {pc, instr}
package riscv_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO holding fetched instructions.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i         : write push_data_i at the tail
//   pop_i          : remove the head entry
//   flush_i        : empty the buffer; wins over push on the same edge
//   count_o        : number of valid entries (0..2)
//   valid_o        : buffer non-empty
//   head_o         : oldest entry, all-zero when empty
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [1:0] count_o,
  output logic       valid_o,
  output entry_t     head_o
);

  entry_t     ent_q [2];
  entry_t     ent_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;
  logic [1:0] tail_idx;

  always_comb begin
    ent_d    = ent_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i && (cnt_q != 2'd0);
    // A full buffer can still accept a push when the head leaves on the same edge.
    do_push  = push_i && ((cnt_q != 2'd2) || do_pop);
    tail_idx = cnt_q - {1'b0, do_pop};
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (do_pop) begin
        ent_d[0] = ent_q[1];
      end
      if (do_push) begin
        ent_d[tail_idx[0]] = push_data_i;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= 2'd0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign count_o = cnt_q;
  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = valid_o ? ent_q[0] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake into a 2-entry buffer and presents the head to the control unit.
// A consumed instruction with PCsrc set redirects fetch to pc + ImmOp.
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req/addr/ack/rdata  : instruction memory handshake
//   instr, pc, instr_valid   : head instruction (zero when empty)
//   instr_ready              : consumer accepts the head this cycle
//   PCsrc, ImmOp             : branch taken / byte offset for the head
module instr_fetch #(
  parameter int unsigned ADDRESS_WIDTH = riscv_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = riscv_pkg::DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(riscv_pkg::RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                     discard_q, discard_d;

  logic [1:0]               cnt;
  logic                     buf_valid;
  entry_t                   head, push_data;
  logic                     consume, redirect, ack_fire, push;
  logic [ADDRESS_WIDTH-1:0] sum, target;

  assign instr_valid = buf_valid;
  assign instr       = head.instr;
  assign pc          = head.pc;

  // While discarding, the in-flight request must stay up until its ack.
  assign imem_req  = !rst && ((cnt != 2'd2) || discard_q);
  assign imem_addr = fetch_pc_q;

  assign consume  = buf_valid && instr_ready;
  assign redirect = consume && PCsrc;
  assign ack_fire = imem_req && imem_ack;
  assign push     = ack_fire && !discard_q && !redirect;

  assign sum    = head.pc + ImmOp;
  assign target = {sum[ADDRESS_WIDTH-1:2], 2'b00};

  assign push_data.pc    = fetch_pc_q;
  assign push_data.instr = imem_rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    discard_d     = discard_q;
    if (redirect) begin
      if (imem_req && !imem_ack) begin
        // Keep the outstanding address stable; jump once its ack returns.
        discard_d     = 1'b1;
        redirect_pc_d = target;
      end else begin
        fetch_pc_d = target;
      end
    end else if (ack_fire) begin
      if (discard_q) begin
        fetch_pc_d = redirect_pc_q;
        discard_d  = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      discard_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      discard_q     <= discard_d;
    end
  end

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_fetch_buffer (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (consume),
    .flush_i     (redirect),
    .count_o     (cnt),
    .valid_o     (buf_valid),
    .head_o      (head)
  );

endmodule
